// File: rtl/frontend_pkg.sv
// frontend_pkg
//   Shared constants and types for the fetch front end.
//   XLEN / CLC_WIDTH / LINE_BITS : address width, cacheline index width, line payload width
//   fetch_entry_t                : one buffered line (line index + 16B payload)
//   fetch_state_t                : miss-handling FSM states
package frontend_pkg;

  localparam int XLEN      = 32;
  localparam int CLC_WIDTH = 28;
  localparam int LINE_BITS = 128;

  typedef struct packed {
    logic [CLC_WIDTH-1:0] addr;
    logic [LINE_BITS-1:0] data;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   DEPTH-entry circular buffer of fetch_entry_t with a combinational head.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : empties the buffer next cycle (pointers and count to zero)
//   push      : write push_data at the tail (caller never pushes when full)
//   pop       : drop the head entry (caller never pops when empty)
//   head      : entry at the read pointer, valid when count != 0
//   count     : occupancy, 0..DEPTH
module fetch_fifo
  import frontend_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap without any compare.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer
//   Buffers I-cache hit lines in program order for decode and back-pressures the
//   cacheline counter. A miss raises one request and blocks until fill_done; the
//   counter keeps re-presenting the line, which then hits.
//   clk, rst                  : clock, synchronous active-high reset
//   resteer                   : flush all buffered state and abandon any miss
//   line_valid_in/line_addr_in: lookup valid and line index being looked up
//   even_hit/even_data        : even-bank result (line_addr_in[0]==0)
//   odd_hit/odd_data          : odd-bank result  (line_addr_in[0]==1)
//   fill_done                 : outstanding miss line is now resident
//   miss_req_valid/addr       : 1-cycle fill request pulse and held miss index
//   stall_out                 : hold the counter on the current index
//   dec_valid/dec_ready       : head handshake with decode
//   dec_pc/dec_line           : head line address and data
module fetch_line_buffer
  import frontend_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resteer,
  input  logic                 line_valid_in,
  input  logic [CLC_WIDTH-1:0] line_addr_in,
  input  logic                 even_hit,
  input  logic [LINE_BITS-1:0] even_data,
  input  logic                 odd_hit,
  input  logic [LINE_BITS-1:0] odd_data,
  input  logic                 fill_done,
  output logic                 miss_req_valid,
  output logic [CLC_WIDTH-1:0] miss_req_addr,
  output logic                 stall_out,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [XLEN-1:0]      dec_pc,
  output logic [LINE_BITS-1:0] dec_line
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t         state;
  logic [CW-1:0]        count;
  fetch_entry_t         head;
  fetch_entry_t         push_entry;
  logic                 sel_hit;
  logic [LINE_BITS-1:0] sel_data;
  logic                 busy;
  logic                 accept;
  logic                 miss_now;
  logic                 dequeue;

  assign sel_hit  = line_addr_in[0] ? odd_hit  : even_hit;
  assign sel_data = line_addr_in[0] ? odd_data : even_data;

  assign busy     = (state == MISS) || (count >= CW'(DEPTH - STALL_MARGIN));
  assign accept   = line_valid_in && !busy &&  sel_hit && !resteer;
  assign miss_now = line_valid_in && !busy && !sel_hit && !resteer;

  // Combinational from the hit inputs so the counter holds on the miss edge itself.
  assign stall_out = busy || miss_now;

  assign dec_valid = (count != '0);
  assign dequeue   = dec_valid && dec_ready && !resteer;

  assign push_entry = '{addr: line_addr_in, data: sel_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (resteer),
    .push      (accept),
    .push_data (push_entry),
    .pop       (dequeue),
    .head      (head),
    .count     (count)
  );

  assign dec_pc   = {head.addr, 4'b0000};
  assign dec_line = head.data;

  // Miss FSM. Fill data is never captured: leaving MISS just releases the stall
  // so the counter re-presents the line, which now hits. A fill_done seen in
  // IDLE belongs to a miss abandoned by resteer and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      miss_req_valid <= 1'b0;
      miss_req_addr  <= '0;
    end else if (resteer) begin
      state          <= IDLE;
      miss_req_valid <= 1'b0;
    end else begin
      miss_req_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_now) begin
            state          <= MISS;
            miss_req_valid <= 1'b1;
            miss_req_addr  <= line_addr_in;
          end
        end
        MISS: begin
          if (fill_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb_fetch_line_buffer
//   Directed scenario bench for fetch_line_buffer. Inputs change just after the
//   falling edge; outputs are sampled 1 time unit later, well away from posedge.
module tb_fetch_line_buffer;
  import frontend_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 resteer;
  logic                 line_valid_in;
  logic [CLC_WIDTH-1:0] line_addr_in;
  logic                 even_hit;
  logic [LINE_BITS-1:0] even_data;
  logic                 odd_hit;
  logic [LINE_BITS-1:0] odd_data;
  logic                 fill_done;
  logic                 miss_req_valid;
  logic [CLC_WIDTH-1:0] miss_req_addr;
  logic                 stall_out;
  logic                 dec_valid;
  logic                 dec_ready;
  logic [XLEN-1:0]      dec_pc;
  logic [LINE_BITS-1:0] dec_line;

  int checks   = 0;
  int failures = 0;

  fetch_line_buffer #(.DEPTH(8), .STALL_MARGIN(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .resteer        (resteer),
    .line_valid_in  (line_valid_in),
    .line_addr_in   (line_addr_in),
    .even_hit       (even_hit),
    .even_data      (even_data),
    .odd_hit        (odd_hit),
    .odd_data       (odd_data),
    .fill_done      (fill_done),
    .miss_req_valid (miss_req_valid),
    .miss_req_addr  (miss_req_addr),
    .stall_out      (stall_out),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_line       (dec_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Distinct payload per line index so a wrong bank or wrong entry is visible.
  function automatic logic [LINE_BITS-1:0] mk(input logic [CLC_WIDTH-1:0] a);
    return {4{4'hA, a}};
  endfunction

  // Selected bank gets the real line; the other bank gets the opposite hit and
  // inverted data so a swapped bank select cannot go unnoticed.
  task automatic present(input logic [CLC_WIDTH-1:0] a, input logic hit);
    line_valid_in = 1'b1;
    line_addr_in  = a;
    if (a[0]) begin
      odd_hit  = hit;   odd_data  = mk(a);
      even_hit = ~hit;  even_data = ~mk(a);
    end else begin
      even_hit = hit;   even_data = mk(a);
      odd_hit  = ~hit;  odd_data  = ~mk(a);
    end
  endtask

  task automatic idle_in();
    line_valid_in = 1'b0;
    line_addr_in  = '0;
    even_hit = 1'b0; odd_hit = 1'b0;
    even_data = '0;  odd_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b want=0", stall_out); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dec_valid got=%0b want=0", dec_valid); end
    checks++; if (miss_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_miss_valid got=%0b want=0", miss_req_valid); end
    checks++; if (miss_req_addr !== '0) begin failures++; $display("[TB] FAIL reset_miss_addr got=%h want=0", miss_req_addr); end
    checks++; if (dut.count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", dut.count); end
  endtask

  task automatic test_hits();
    logic [CLC_WIDTH-1:0] a;
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = CLC_WIDTH'(28'h10 + i);
      present(a, 1'b1);
      #1;
      checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL hits_stall i=%0d got=%0b want=0", i, stall_out); end
      if (i > 0) begin
        checks++; if (dec_pc !== 32'h100 + 32'(i - 1) * 32'h10) begin failures++; $display("[TB] FAIL hits_pc i=%0d got=%h want=%h", i, dec_pc, 32'h100 + 32'(i - 1) * 32'h10); end
      end
    end
    @(negedge clk); idle_in(); #1;
    checks++; if (dec_pc !== 32'h120) begin failures++; $display("[TB] FAIL hits_pc_last got=%h want=120", dec_pc); end
    checks++; if (dec_line !== mk(28'h12)) begin failures++; $display("[TB] FAIL hits_line_last got=%h want=%h", dec_line, mk(28'h12)); end
    @(negedge clk); dec_ready = 1'b0; #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL hits_drained got=%0b want=0", dec_valid); end
  endtask

  task automatic test_miss();
    dec_ready = 1'b0;
    @(negedge clk); present(28'h21, 1'b0); #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("[TB] FAIL miss_stall_same got=%0b want=1", stall_out); end
    @(negedge clk); #1;
    checks++; if (miss_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL miss_req_pulse got=%0b want=1", miss_req_valid); end
    checks++; if (miss_req_addr !== 28'h21) begin failures++; $display("[TB] FAIL miss_req_addr got=%h want=21", miss_req_addr); end
    @(negedge clk); #1;
    checks++; if (miss_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL miss_pulse_width got=%0b want=0", miss_req_valid); end
    checks++; if (stall_out !== 1'b1) begin failures++; $display("[TB] FAIL miss_stall_hold got=%0b want=1", stall_out); end
    repeat (3) @(negedge clk);
    fill_done = 1'b1; #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("[TB] FAIL miss_stall_fill got=%0b want=1", stall_out); end
    @(negedge clk); fill_done = 1'b0; present(28'h21, 1'b1); #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL miss_stall_release got=%0b want=0", stall_out); end
    checks++; if (dut.count !== 4'd0) begin failures++; $display("[TB] FAIL miss_nothing_buffered got=%0d want=0", dut.count); end
    @(negedge clk); idle_in(); #1;
    checks++; if (dut.count !== 4'd1) begin failures++; $display("[TB] FAIL miss_enq_once got=%0d want=1", dut.count); end
    checks++; if (dec_pc !== 32'h210) begin failures++; $display("[TB] FAIL miss_pc got=%h want=210", dec_pc); end
    checks++; if (dec_line !== mk(28'h21)) begin failures++; $display("[TB] FAIL miss_line got=%h want=%h", dec_line, mk(28'h21)); end
    checks++; if (miss_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL miss_no_repulse got=%0b want=0", miss_req_valid); end
    dec_ready = 1'b1;
    @(negedge clk); dec_ready = 1'b0; #1;
    checks++; if (dut.count !== 4'd0) begin failures++; $display("[TB] FAIL miss_drain got=%0d want=0", dut.count); end
  endtask

  task automatic test_full();
    dec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); present(CLC_WIDTH'(28'h30 + i), 1'b1); #1;
      checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL full_fill_stall i=%0d got=%0b want=0", i, stall_out); end
    end
    @(negedge clk); present(28'h38, 1'b1); #1;
    checks++; if (dut.count !== 4'd8) begin failures++; $display("[TB] FAIL full_count got=%0d want=8", dut.count); end
    checks++; if (stall_out !== 1'b1) begin failures++; $display("[TB] FAIL full_stall got=%0b want=1", stall_out); end
    @(negedge clk); #1;
    checks++; if (dut.count !== 4'd8) begin failures++; $display("[TB] FAIL full_no_enq got=%0d want=8", dut.count); end
    checks++; if (dec_pc !== 32'h300) begin failures++; $display("[TB] FAIL full_head got=%h want=300", dec_pc); end
    dec_ready = 1'b1;
    @(negedge clk); dec_ready = 1'b0; #1;
    checks++; if (dut.count !== 4'd7) begin failures++; $display("[TB] FAIL full_pop_count got=%0d want=7", dut.count); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL full_stall_drop got=%0b want=0", stall_out); end
    @(negedge clk); idle_in(); #1;
    checks++; if (dut.count !== 4'd8) begin failures++; $display("[TB] FAIL full_held_enq got=%0d want=8", dut.count); end
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (dec_pc !== 32'h310 + 32'(i) * 32'h10) begin failures++; $display("[TB] FAIL full_order i=%0d got=%h want=%h", i, dec_pc, 32'h310 + 32'(i) * 32'h10); end
      @(negedge clk); #1;
    end
    dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_drained got=%0b want=0", dec_valid); end
  endtask

  task automatic test_resteer();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); present(CLC_WIDTH'(28'h40 + i), 1'b1);
    end
    @(negedge clk); present(28'h45, 1'b0);
    @(negedge clk); #1;
    checks++; if (dut.state !== MISS) begin failures++; $display("[TB] FAIL rs_in_miss got=%0d want=1", dut.state); end
    checks++; if (dut.count !== 4'd5) begin failures++; $display("[TB] FAIL rs_count5 got=%0d want=5", dut.count); end
    resteer = 1'b1; dec_ready = 1'b1; present(28'h46, 1'b1);
    @(negedge clk); resteer = 1'b0; dec_ready = 1'b0; idle_in(); #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL rs_dec_valid got=%0b want=0", dec_valid); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("[TB] FAIL rs_idle got=%0d want=0", dut.state); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL rs_stall got=%0b want=0", stall_out); end
    fill_done = 1'b1;
    @(negedge clk); fill_done = 1'b0; #1;
    checks++; if (dut.state !== IDLE) begin failures++; $display("[TB] FAIL rs_late_fill got=%0d want=0", dut.state); end
    checks++; if (miss_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rs_no_req got=%0b want=0", miss_req_valid); end
    @(negedge clk); #1;
    checks++; if (miss_req_valid !== 1'b0 || dut.count !== 4'd0) begin failures++; $display("[TB] FAIL rs_quiet got=%0b/%0d want=0/0", miss_req_valid, dut.count); end
  endtask

  task automatic test_back_to_back();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); present(CLC_WIDTH'(28'h50 + i), 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); dec_ready = 1'b1; present(CLC_WIDTH'(28'h53 + i), 1'b1); #1;
      checks++; if (dut.count !== 4'd3) begin failures++; $display("[TB] FAIL b2b_count i=%0d got=%0d want=3", i, dut.count); end
      checks++; if (dec_pc !== 32'h500 + 32'(i) * 32'h10) begin failures++; $display("[TB] FAIL b2b_order i=%0d got=%h want=%h", i, dec_pc, 32'h500 + 32'(i) * 32'h10); end
    end
    @(negedge clk); idle_in(); #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dec_line !== mk(CLC_WIDTH'(28'h5A + i))) begin failures++; $display("[TB] FAIL b2b_tail i=%0d got=%h want=%h", i, dec_line, mk(CLC_WIDTH'(28'h5A + i))); end
      @(negedge clk); #1;
    end
    dec_ready = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drained got=%0b want=0", dec_valid); end
  endtask

  task automatic test_rst_mid_miss();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); present(CLC_WIDTH'(28'h60 + i), 1'b1);
    end
    @(negedge clk); present(28'h65, 1'b0);
    @(negedge clk); #1;
    checks++; if (miss_req_addr !== 28'h65) begin failures++; $display("[TB] FAIL rst_pre_addr got=%h want=65", miss_req_addr); end
    rst = 1'b1; idle_in();
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_dec_valid got=%0b want=0", dec_valid); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall got=%0b want=0", stall_out); end
    checks++; if (miss_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_miss_valid got=%0b want=0", miss_req_valid); end
    checks++; if (miss_req_addr !== '0) begin failures++; $display("[TB] FAIL rst_miss_addr got=%h want=0", miss_req_addr); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("[TB] FAIL rst_state got=%0d want=0", dut.state); end
    present(28'h70, 1'b1);
    @(negedge clk); idle_in(); #1;
    checks++; if (dut.count !== 4'd1) begin failures++; $display("[TB] FAIL rst_after_count got=%0d want=1", dut.count); end
    checks++; if (dec_pc !== 32'h700) begin failures++; $display("[TB] FAIL rst_after_pc got=%h want=700", dec_pc); end
    checks++; if (dec_line !== mk(28'h70)) begin failures++; $display("[TB] FAIL rst_after_line got=%h want=%h", dec_line, mk(28'h70)); end
  endtask

  initial begin
    rst = 1'b1; resteer = 1'b0; fill_done = 1'b0; dec_ready = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_hits();
    test_miss();
    test_full();
    test_resteer();
    test_back_to_back();
    test_rst_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
